// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for a register bank: round-robin between ALU and load ports,
// one-cycle registered write, and a pending-write scoreboard for hazard detection.
module regbank_wb_arbiter #(
  parameter int WIDTH  = 5,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [WIDTH-1:0]      req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [WIDTH-1:0]      req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  input  logic                  reserve_valid,
  input  logic [WIDTH-1:0]      reserve_addr,
  input  logic [WIDTH-1:0]      register1,
  input  logic [WIDTH-1:0]      register2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [WIDTH-1:0]      register3,
  output logic [DATA_W-1:0]     datain,
  output logic                  regwrite,
  output logic [(2**WIDTH)-1:0] pending
);

  localparam int NREG = 2**WIDTH;

  logic              last_grant_r;
  logic              regwrite_r;
  logic [WIDTH-1:0]  register3_r;
  logic [DATA_W-1:0] datain_r;
  logic [NREG-1:0]   pending_r;

  logic              grant0_s;
  logic              grant1_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  xfer_addr_s;
  logic [DATA_W-1:0] xfer_data_s;
  logic              xfer_wr_s;
  logic [NREG-1:0]   set_s;
  logic [NREG-1:0]   clr_s;
  logic [NREG-1:0]   pending_nxt_s;

  // Arbitration: alternate on contention, last_grant_r=1 means port 0 goes next
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // Selected transfer and scoreboard next-state; set is applied after clear so it wins
  always_comb begin
    xfer_s      = grant0_s | grant1_s;
    xfer_addr_s = {WIDTH{1'b0}};
    xfer_data_s = {DATA_W{1'b0}};
    set_s       = {NREG{1'b0}};
    clr_s       = {NREG{1'b0}};
    if (grant1_s) begin
      xfer_addr_s = req1_addr;
      xfer_data_s = req1_data;
    end else begin
      xfer_addr_s = req0_addr;
      xfer_data_s = req0_data;
    end
    xfer_wr_s = xfer_s && (xfer_addr_s != {WIDTH{1'b0}});
    if (xfer_wr_s) begin
      clr_s[xfer_addr_s] = 1'b1;
    end else begin
      clr_s = {NREG{1'b0}};
    end
    if (!rst && reserve_valid && (reserve_addr != {WIDTH{1'b0}})) begin
      set_s[reserve_addr] = 1'b1;
    end else begin
      set_s = {NREG{1'b0}};
    end
    pending_nxt_s    = (pending_r & ~clr_s) | set_s;
    pending_nxt_s[0] = 1'b0;
  end

  // State registers: priority, write port pipeline and scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      regwrite_r   <= 1'b0;
      register3_r  <= {WIDTH{1'b0}};
      datain_r     <= {DATA_W{1'b0}};
      pending_r    <= {NREG{1'b0}};
    end else begin
      if (xfer_s) begin
        last_grant_r <= grant1_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      regwrite_r <= xfer_wr_s;
      if (xfer_wr_s) begin
        register3_r <= xfer_addr_s;
        datain_r    <= xfer_data_s;
      end else begin
        register3_r <= register3_r;
        datain_r    <= datain_r;
      end
      pending_r <= pending_nxt_s;
    end
  end

  // Reset kills a write pulse already captured on the previous edge
  assign regwrite   = regwrite_r & ~rst;
  assign register3  = register3_r;
  assign datain     = datain_r;
  assign pending    = pending_r;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign hazard1    = pending_r[register1];
  assign hazard2    = pending_r[register2];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomized and directed bench for regbank_wb_arbiter against a behavioural model.
module tb_regbank_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, reserve_valid;
  logic [4:0]  req0_addr, req1_addr, reserve_addr, register1, register2;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, hazard1, hazard2, regwrite;
  logic [4:0]  register3;
  logic [63:0] datain;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit          mp [32];
  int          mlast;
  bit          mwr;
  logic [4:0]  mr3;
  logic [63:0] mdin;
  bit          mvalid = 1'b0;

  regbank_wb_arbiter #(.WIDTH(5), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .register1(register1), .register2(register2),
    .hazard1(hazard1), .hazard2(hazard2),
    .register3(register3), .datain(datain), .regwrite(regwrite), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mgrant();
    if (rst) return -1;
    if (req0_valid && req1_valid) return (mlast == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  task automatic compare();
    int g;
    if (mvalid) begin
      g = mgrant();
      chk("req0_ready", req0_ready, (g == 0) ? 64'd1 : 64'd0);
      chk("req1_ready", req1_ready, (g == 1) ? 64'd1 : 64'd0);
      chk("regwrite", regwrite, (mwr && !rst) ? 64'd1 : 64'd0);
      chk("register3", register3, mr3);
      chk("datain", datain, mdin);
      chk("pending", pending, mpend());
      chk("hazard1", hazard1, mp[register1]);
      chk("hazard2", hazard2, mp[register2]);
    end
  endtask

  task automatic model_edge();
    int g;
    logic [4:0]  a;
    logic [63:0] d;
    g = mgrant();
    if (rst) begin
      for (int i = 0; i < 32; i++) mp[i] = 1'b0;
      mlast = 1; mwr = 1'b0; mr3 = 5'd0; mdin = 64'd0; mvalid = 1'b1;
    end else begin
      mwr = 1'b0;
      if (g >= 0) begin
        mlast = g;
        a = (g == 1) ? req1_addr : req0_addr;
        d = (g == 1) ? req1_data : req0_data;
        if (a != 5'd0) begin
          mwr = 1'b1; mr3 = a; mdin = d; mp[a] = 1'b0;
        end
      end
      if (reserve_valid && reserve_addr != 5'd0) mp[reserve_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0; reserve_valid = 1'b0;
    req0_addr = 5'd0; req1_addr = 5'd0; reserve_addr = 5'd0;
    req0_data = 64'd0; req1_data = 64'd0; register1 = 5'd0; register2 = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_regwrite", regwrite, 64'd0);
    chk("reset_register3", register3, 64'd0);
    chk("reset_pending", pending, 64'd0);

    // Single request on port 0
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h123456789ABCDEF0;
    #1 chk("single_ready", req0_ready, 64'd1);
    tick(); idle();
    #1;
    chk("single_regwrite", regwrite, 64'd1);
    chk("single_register3", register3, 64'd5);
    chk("single_datain", datain, 64'h123456789ABCDEF0);
    tick();
    chk("single_regwrite_off", regwrite, 64'd0);

    // Contention from reset alternates 0,1,0,1 with no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'hA0 + 64'(i);
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'hB0 + 64'(i);
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 64'd1 : 64'd0);
      if (i > 0) begin
        chk("rr_regwrite", regwrite, 64'd1);
        chk("rr_register3", register3, (i % 2 == 1) ? 64'd1 : 64'd2);
      end
      tick();
    end
    idle();
    #1;
    chk("rr_regwrite_last", regwrite, 64'd1);
    chk("rr_register3_last", register3, 64'd2);

    // Reservation raises a hazard until the write lands
    do_reset();
    reserve_valid = 1'b1; reserve_addr = 5'd7; tick(); idle();
    register1 = 5'd7;
    #1 chk("haz_set", hazard1, 64'd1);
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h77;
    #1 chk("haz_no_bypass", hazard1, 64'd1);
    tick(); idle(); register1 = 5'd7;
    #1;
    chk("haz_pending7", pending[7], 64'd0);
    chk("haz_clear", hazard1, 64'd0);

    // Set beats clear on the same address; x0 never writes or reserves
    reserve_valid = 1'b1; reserve_addr = 5'd3;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h33;
    tick(); idle();
    #1 chk("setwins_pending3", pending[3], 64'd1);
    do_reset();
    reserve_valid = 1'b1; reserve_addr = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 64'hFF;
    #1 chk("x0_ready", req0_ready, 64'd1);
    tick(); idle();
    #1;
    chk("x0_regwrite", regwrite, 64'd0);
    chk("x0_pending", pending, 64'd0);

    // Reset during a transfer, and reset right after a captured transfer
    reserve_valid = 1'b1; reserve_addr = 5'd4; tick();
    reserve_addr = 5'd9; tick(); idle();
    #1 chk("pre_rst_pending", pending, 64'h210);
    rst = 1'b1; req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 64'h66;
    #1 chk("rst_ready0", req0_ready, 64'd0);
    tick(); rst = 1'b0; idle();
    #1;
    chk("rst_pending", pending, 64'd0);
    chk("rst_regwrite", regwrite, 64'd0);
    req0_valid = 1'b1; req0_addr = 5'd8; req1_valid = 1'b1; req1_addr = 5'd10;
    #1;
    chk("post_rst_ready0", req0_ready, 64'd1);
    chk("post_rst_ready1", req1_ready, 64'd0);
    tick(); idle(); rst = 1'b1;
    #1 chk("rst_suppress_pulse", regwrite, 64'd0);
    tick(); rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      req0_valid    = $urandom_range(0, 1);
      req1_valid    = $urandom_range(0, 1);
      req0_addr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      req1_addr     = 5'($urandom_range(0, 7));
      req0_data     = {$urandom, $urandom};
      req1_data     = {$urandom, $urandom};
      reserve_valid = $urandom_range(0, 1);
      reserve_addr  = ($urandom_range(0, 1) == 0) ? req0_addr : 5'($urandom_range(0, 31));
      register1     = 5'($urandom_range(0, 31));
      register2     = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 5: register address width; register count is 2**WIDTH.
REQ-002 Parameter DATA_W, default 64: register data width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  writeback request, port 0 (ALU path).
REQ-006 req0_addr  input  WIDTH  destination register, port 0.
REQ-007 req0_data  input  DATA_W  write data, port 0.
REQ-008 req0_ready  output  1  grant, port 0; a transfer occurs when valid and ready are both high.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready: same widths and meanings as REQ-005..008, port 1 (load path).
REQ-010 reserve_valid  input  1  a destination is reserved at issue time.
REQ-011 reserve_addr  input  WIDTH  register being reserved.
REQ-012 register1, register2  input  WIDTH  source addresses to check for hazards.
REQ-013 hazard1, hazard2  output  1  the source register has a pending write.
REQ-014 register3  output  WIDTH  write address to the register bank.
REQ-015 datain  output  DATA_W  write data to the register bank.
REQ-016 regwrite  output  1  write enable to the register bank.
REQ-017 pending  output  2**WIDTH  scoreboard: one bit per register.

Function
REQ-018 The block SHALL grant at most one port per cycle; reqN_ready is combinational from the valid inputs and the priority state, and is never high while reqN_valid is low.
REQ-019 The block SHALL hold a 1-bit last_grant register; if both ports are valid, it SHALL grant the port that is not last_grant.
REQ-020 If exactly one port is valid, the block SHALL grant that port.
REQ-021 last_grant SHALL update to the granted port at every transfer and hold otherwise.
REQ-022 The block SHALL register an accepted transfer: on the next cycle regwrite=1 for exactly one cycle, and register3/datain equal the accepted address and data (latency 1).
REQ-023 On a cycle after a cycle with no transfer, regwrite SHALL be 0; register3 and datain SHALL hold their last values.
REQ-024 Back-to-back transfers SHALL produce regwrite=1 on consecutive cycles, with no bubble.
REQ-025 A transfer to address 0 SHALL complete its handshake, but regwrite SHALL stay 0 on the following cycle (x0 is hardwired).
REQ-026 On reserve_valid=1 with reserve_addr≠0, pending[reserve_addr] SHALL set at the clock edge.
REQ-027 A transfer to address n≠0 SHALL clear pending[n] at the same edge that captures the transfer.
REQ-028 If a set and a clear target the same address at the same edge, set SHALL win.
REQ-029 Set and clear of different addresses at the same edge SHALL both take effect.
REQ-030 pending[0] SHALL read as constant 0.
REQ-031 A write to a non-pending register SHALL be performed normally and leave pending unchanged.
REQ-032 hazard1 SHALL equal pending[register1] combinationally; hazard2 SHALL equal pending[register2]; both SHALL be 0 for address 0.
REQ-033 Hazard outputs SHALL reflect registered state only, with no combinational bypass from the same-cycle transfer.

Reset
REQ-034 While rst=1 at an edge, the block SHALL force regwrite=0, register3=0, datain=0, pending=0 and last_grant=1 (port 0 is preferred first).
REQ-035 While rst=1, req0_ready and req1_ready SHALL be 0, and no transfer or reservation SHALL be recorded.
REQ-036 Reset asserted with a transfer captured on the previous edge SHALL suppress that transfer's regwrite pulse.
REQ-037 After rst falls, the first edge SHALL operate normally.

Verification
REQ-038 Reset, then req0 (addr 5, data 64'h123456789ABCDEF0) alone -> req0_ready=1; next cycle regwrite=1, register3=5, datain=64'h123456789ABCDEF0; following cycle regwrite=0.
REQ-039 Both ports valid for 4 cycles (req0 addr 1, req1 addr 2) from reset -> grants 0,1,0,1; regwrite high on 4 consecutive cycles; register3 sequence 1,2,1,2.
REQ-040 Reserve addr 7, then register1=7 -> hazard1=1 from the next cycle; req1 write to addr 7 -> pending[7]=0 and hazard1=0 on the cycle after the transfer.
REQ-041 Same edge: reserve addr 3 and transfer to addr 3 -> pending[3]=1 afterwards; transfer to addr 0 with reserve addr 0 -> regwrite stays 0 and pending=0.
REQ-042 Pending bits 4 and 9 set; assert rst for 1 cycle during a req0 transfer -> pending=0, no regwrite pulse; after release, req0 and req1 valid together -> req0 granted first.
